// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM encoding, the
// hard-wired zero register and the width of the MDU stall counter.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Register r0 never holds a live load result, so it can't cause a hazard.
  localparam int REG_ZERO = 0;

  // Wide enough for MDU_CYCLES-1 up to 14.
  localparam int CNT_BITS = 4;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID-stage datapath (master) and the hazard controller
// (slave): the decoded hazard sources in, and the pipeline controls out.
interface hazard_ctrl_if #(
  parameter int REG_BITS = 5
);

  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic                id_uses_rt;
  logic                idex_memRead;
  logic [REG_BITS-1:0] idex_rt;
  logic                branch_taken;
  logic                jump;
  logic                mdu_start;
  logic                pc_write;
  logic                ifid_write;
  logic                if_flush;
  logic                idex_bubble;
  logic                mdu_busy;

  modport master (
    output id_rs, id_rt, id_uses_rt, idex_memRead, idex_rt,
           branch_taken, jump, mdu_start,
    input  pc_write, ifid_write, if_flush, idex_bubble, mdu_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_memRead, idex_rt,
           branch_taken, jump, mdu_start,
    output pc_write, ifid_write, if_flush, idex_bubble, mdu_busy
  );

endinterface

// File: rtl/hazard_stall_counter.sv
// Loadable down-counter timing how long the front end stays frozen
// behind a multi-cycle MDU operation.
module hazard_stall_counter
  import hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                init,
  input  logic                load,
  input  logic [CNT_BITS-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [CNT_BITS-1:0] cnt;

  // Load takes precedence over decrement; init clears the count at once.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller in ID: load-use detection, fetch redirect flush and a
// fixed-length front-end freeze while the MDU runs. Outputs are purely
// combinational from state and current inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 4,
  parameter int REG_BITS   = 5
) (
  input  logic           clk,
  input  logic           init,
  hazard_ctrl_if.slave   bus
);

  state_t              state;
  state_t              state_next;
  logic [REG_BITS-1:0] rs;
  logic [REG_BITS-1:0] rt;
  logic [REG_BITS-1:0] ex_rt;
  logic                lu;
  logic                redirect;
  logic                cnt_zero;
  logic                cnt_load;
  logic                cnt_dec;
  logic                pc_write;
  logic                ifid_write;
  logic                if_flush;
  logic                idex_bubble;

  assign rs       = bus.id_rs;
  assign rt       = bus.id_rt;
  assign ex_rt    = bus.idex_rt;
  assign redirect = bus.branch_taken | bus.jump;

  // A load in EX feeding a source of the ID instruction; rt only counts
  // when the instruction actually reads it.
  assign lu = bus.idex_memRead
              && (ex_rt != REG_BITS'(REG_ZERO))
              && ((ex_rt == rs) || (bus.id_uses_rt && (ex_rt == rt)));

  hazard_stall_counter u_cnt (
    .clk      (clk),
    .init     (init),
    .load     (cnt_load),
    .load_val (CNT_BITS'(MDU_CYCLES - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register; init drops straight back to RUN.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and output decode, priority BUSY > load-use > redirect > normal.
  always_comb begin
    state_next  = state;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    if_flush    = 1'b0;
    idex_bubble = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    if (init) begin
      // Hold PC, let IF/ID capture its cleared contents, bubble ID/EX.
      pc_write    = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      case (state)
        BUSY: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          cnt_dec     = ~cnt_zero;
          if (cnt_zero) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (lu) begin
            // Redirects and MDU issue wait: IF/ID holds, so they reappear.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else begin
            if_flush = redirect;
            if (bus.mdu_start) begin
              cnt_load   = 1'b1;
              state_next = BUSY;
            end
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.if_flush    = if_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.mdu_busy    = (state == BUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. The stimulus process drives one vector per
// cycle and queues the hand-computed output word for that cycle; a monitor
// on the falling edge pops and compares against the DUT.
// Output word order: {pc_write, ifid_write, if_flush, idex_bubble, mdu_busy}.
module tb_hazard_ctrl;

  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11100;
  localparam logic [4:0] BUSYV = 5'b00011;
  localparam logic [4:0] RSTV  = 5'b01010;

  logic clk;
  logic init;
  int   checks;
  int   failures;

  logic [4:0] exp_q[$];
  string      name_q[$];

  hazard_ctrl_if #(.REG_BITS(5)) bus ();

  hazard_ctrl #(.MDU_CYCLES(4), .REG_BITS(5)) dut (
    .clk  (clk),
    .init (init),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mr, input logic [4:0] ert,
                       input logic br, input logic jp, input logic ms);
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_uses_rt   = urt;
    bus.idex_memRead = mr;
    bus.idex_rt      = ert;
    bus.branch_taken = br;
    bus.jump         = jp;
    bus.mdu_start    = ms;
  endtask

  // Queue the expectation for the current cycle, then advance one cycle.
  task automatic cyc(input logic [4:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are compared mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    logic [4:0] got;
    logic [4:0] e;
    string      n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      got = {bus.pc_write, bus.ifid_write, bus.if_flush, bus.idex_bubble, bus.mdu_busy};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s got=%b expected=%b", n, got, e);
      end else begin
        $display("txn %0d %s out=%b", checks, n, got);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    init     = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Reset state.
    repeat (2) cyc(RSTV, "reset");
    init = 1'b0;
    cyc(NORM, "idle");

    // Load-use on rs, then load gone.
    drive(8, 0, 0, 1, 8, 0, 0, 0);  cyc(STALL, "lu_rs");
    drive(8, 0, 0, 0, 0, 0, 0, 0);  cyc(NORM, "lu_after");
    // Load into r0 never stalls.
    drive(0, 0, 1, 1, 0, 0, 0, 0);  cyc(NORM, "lu_r0");
    // rt match only matters when rt is a source.
    drive(3, 7, 0, 1, 7, 0, 0, 0);  cyc(NORM, "lu_rt_unused");
    drive(3, 7, 1, 1, 7, 0, 0, 0);  cyc(STALL, "lu_rt");
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc(NORM, "lu_rt_after");

    // Taken branch with no hazard.
    drive(1, 2, 1, 0, 0, 1, 0, 0);  cyc(FLUSH, "branch");
    drive(1, 2, 1, 0, 0, 0, 0, 0);  cyc(NORM, "branch_after");

    // Branch together with load-use: stall first, flush next cycle.
    drive(4, 9, 1, 1, 9, 1, 0, 0);  cyc(STALL, "br_lu_c1");
    drive(4, 9, 1, 0, 0, 1, 0, 0);  cyc(FLUSH, "br_lu_c2");
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc(NORM, "br_lu_after");

    // MDU op with jump held through the BUSY window.
    drive(0, 0, 0, 0, 0, 0, 0, 1);  cyc(NORM, "mdu_issue");
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) cyc(BUSYV, "mdu_busy");
    cyc(FLUSH, "mdu_jump_c5");
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc(NORM, "mdu_after");

    // MDU issue together with a taken branch: flush and enter BUSY.
    drive(0, 0, 0, 0, 0, 1, 0, 1);  cyc(FLUSH, "mdu_br_issue");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc(BUSYV, "mdu_br_busy");
    cyc(NORM, "mdu_br_after");

    // Reset asserted on BUSY cycle 2, between clock edges.
    drive(0, 0, 0, 0, 0, 0, 0, 1);  cyc(NORM, "rst_mdu_issue");
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc(BUSYV, "rst_busy1");
    init = 1'b1;
    cyc(RSTV, "rst_mid_busy");
    cyc(RSTV, "rst_hold");
    init = 1'b0;
    cyc(NORM, "rst_release");
    cyc(NORM, "rst_release2");

    // Back-to-back MDU ops, mdu_start held; a load-use in BUSY is ignored.
    drive(0, 0, 0, 0, 0, 0, 0, 1);  cyc(NORM, "b2b_issue1");
    repeat (4) cyc(BUSYV, "b2b_busy1");
    cyc(NORM, "b2b_issue2");
    drive(5, 0, 0, 1, 5, 0, 0, 0);
    repeat (4) cyc(BUSYV, "b2b_busy2");
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc(NORM, "b2b_after");

    // Every queued expectation must have been consumed by the monitor.
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0 pending", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the stall and flush controls of the IF/ID pipeline register and the PC, and the bubble select of the ID/EX register. It detects load-use hazards, redirects fetch on taken branches and jumps, and freezes the front end for a fixed number of cycles while the multi-cycle multiply/divide unit (MDU) runs. It sits in ID, beside the register file, and is the only source of `ifid_write` and `if_flush`.

## Interface
Parameters:
- `MDU_CYCLES`, default 4: MDU execution latency in cycles; legal range 2..15.
- `REG_BITS`, default 5: register-specifier width.

Ports:
- `clk`  in  1: pipeline clock; all state changes on the rising edge.
- `init`  in  1: asynchronous, active-high reset.
- `id_rs`  in  REG_BITS: rs field of the instruction in ID.
- `id_rt`  in  REG_BITS: rt field of the instruction in ID.
- `id_uses_rt`  in  1: ID instruction reads rt as a source.
- `idex_memRead`  in  1: instruction in EX is a load.
- `idex_rt`  in  REG_BITS: destination of the load in EX.
- `branch_taken`  in  1: branch in ID resolved taken.
- `jump`  in  1: jump in ID.
- `mdu_start`  in  1: instruction in ID is an MDU op.
- `pc_write`  out  1: PC load enable.
- `ifid_write`  out  1: IF/ID `writeEnable`.
- `if_flush`  out  1: IF/ID `ifFlush` (insert all-zero nop).
- `idex_bubble`  out  1: ID/EX loads zero controls.
- `mdu_busy`  out  1: FSM is in BUSY.

## Operation
- FSM states: RUN, BUSY. A down-counter `cnt` of 4 bits is used only in BUSY.
- Load-use hazard `lu` is asserted when all of the following hold: `idex_memRead`, `idex_rt != 0`, and either `idex_rt == id_rs` or (`id_uses_rt` and `idex_rt == id_rt`).
- RUN with `lu`:
  - `pc_write=0`, `ifid_write=0`, `idex_bubble=1`, `if_flush=0`.
  - Branch, jump and `mdu_start` are ignored this cycle. They are re-seen next cycle because IF/ID holds.
- RUN, no `lu`, with `branch_taken|jump`: `pc_write=1`, `ifid_write=1`, `if_flush=1`, `idex_bubble=0`.
- RUN, no `lu`, with `mdu_start`:
  - Outputs are normal advance (`pc_write=ifid_write=1`, others 0); the MDU op issues to EX.
  - Next state is BUSY, `cnt <= MDU_CYCLES-1`.
  - If `branch_taken|jump` is also asserted, the flush rule applies as well.
- RUN otherwise: `pc_write=1`, `ifid_write=1`, `if_flush=0`, `idex_bubble=0`.
- BUSY:
  - `pc_write=0`, `ifid_write=0`, `if_flush=0`, `idex_bubble=1`, `mdu_busy=1`.
  - All inputs are ignored, including `mdu_start` and redirects.
  - `cnt` decrements each cycle; when `cnt==0`, next state is RUN.
- Priority: BUSY > `lu` > redirect > normal.

## Timing
- Reset (`init=1`, asynchronous):
  - State becomes RUN and `cnt=0`.
  - Outputs are forced `pc_write=0`, `ifid_write=1` (so IF/ID captures its init zeros), `if_flush=0`, `idex_bubble=1`, `mdu_busy=0`.
- After `init` deasserts, the first edge behaves per RUN rules.
- All outputs are combinational from state plus current inputs, with no registered delay. `mdu_busy` depends on state only.
- BUSY lasts exactly `MDU_CYCLES` consecutive cycles, starting the cycle after the `mdu_start` edge.
- Load-use stall lasts exactly one cycle, since the load leaves EX and the bubble enters.
- A redirect pending during BUSY or `lu` asserts `if_flush` on the first eligible RUN cycle.
- `init` asserted mid-BUSY aborts immediately to RUN; no residual stall.
- Back-to-back MDU ops: a second `mdu_start` seen on the first RUN cycle after BUSY re-enters BUSY with a full `MDU_CYCLES` count.

## Structure
- Shared package holds:
  - state encoding (RUN=0, BUSY=1);
  - `REG_ZERO = 0`;
  - the counter width constant (4).
- Sub-module `hazard_stall_counter`: loadable 4-bit down-counter with async reset, inputs `load`/`load_val`/`dec`, output `zero`.
- Top level holds the state flop, `lu` comparator, and output decode.

## Test plan
- Load-use: `idex_memRead=1`, `idex_rt=8`, `id_rs=8`. Required: exactly one cycle of `pc_write=0`, `ifid_write=0`, `idex_bubble=1`. With `idex_rt=0` instead: no stall.
- Branch: `branch_taken=1` in RUN with no hazard. Required: `if_flush=1`, `pc_write=1` for one cycle.
- Branch + load-use together (`idex_rt=id_rt=9`, `id_uses_rt=1`, `branch_taken=1`). Required:
  - cycle 1: stall with `if_flush=0`;
  - cycle 2: `if_flush=1`.
- MDU with `MDU_CYCLES=4`: `mdu_start` pulse. Required: `mdu_busy=1` and stall outputs for exactly 4 cycles, then normal; `jump=1` held throughout flushes on cycle 5.
- Reset mid-BUSY: assert `init` on BUSY cycle 2. Required:
  - `mdu_busy` drops asynchronously;
  - `ifid_write=1`, `pc_write=0`, `idex_bubble=1` while `init` is high;
  - RUN after release.
- Back-to-back `mdu_start`. Required: two BUSY windows of 4 separated by exactly one RUN cycle.
